credit_accum: RTL and testbench

- Registered, parametrised coin-credit accumulator for the vending datapath. It replaces the fixed 4-input combinational credit sum.
- Accepts N coin channels, each a one-cycle pulse with a per-channel value. Holds running credit, saturating against MAX_CREDIT.
- Serves purchase requests through a req/ack handshake, debiting the price when affordable.
- Returns all credit as change on a refund request.
- Sits between the coin-detect front end and the vend/dispense controller.

---
 rtl/vend_pkg.sv | 22 ++
 rtl/coin_adder.sv | 27 ++
 rtl/credit_accum.sv | 136 +++++++++++++
 tb/tb_credit_accum.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// vend_pkg : shared types and default constants for the vending credit path
// Rev 1.0
// ============================================================================
package vend_pkg;

  localparam int CENTS_W        = 7;
  localparam int DEF_NUM_COIN   = 3;
  localparam int DEF_MAX_CREDIT = 100;
  // Index i is the value of coin_pulse[i]: bit 0 = 5c, bit 1 = 10c, bit 2 = 25c.
  localparam int DEF_COIN_VAL [DEF_NUM_COIN-1:0] = '{25, 10, 5};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VEND     = 2'd1,
    REFUND   = 2'd2,
    WAIT_REL = 2'd3
  } credit_state_t;

endpackage
`default_nettype wire

// File: rtl/coin_adder.sv
`default_nettype none
// ============================================================================
// coin_adder : combinational sum of the values of all pulsed coin channels
// Rev 1.0
// ============================================================================
module coin_adder
  import vend_pkg::*;
#(
  parameter int NUM_COIN = DEF_NUM_COIN,
  parameter int OUT_W    = CENTS_W + 2,
  parameter int COIN_VAL [NUM_COIN-1:0] = DEF_COIN_VAL
) (
  input  logic [NUM_COIN-1:0] coin_pulse,
  output logic [OUT_W-1:0]    coin_in
);

  always_comb begin
    coin_in = '0;
    for (int i = 0; i < NUM_COIN; i++) begin
      if (coin_pulse[i]) begin
        coin_in = coin_in + OUT_W'(COIN_VAL[i]);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/credit_accum.sv
`default_nettype none
// ============================================================================
// credit_accum : registered coin-credit accumulator with buy/refund handshake
// Rev 1.0
// ============================================================================
module credit_accum
  import vend_pkg::*;
#(
  parameter int NUM_COIN   = DEF_NUM_COIN,
  parameter int CREDIT_W   = CENTS_W,
  parameter int COIN_VAL [NUM_COIN-1:0] = DEF_COIN_VAL,
  parameter int MAX_CREDIT = DEF_MAX_CREDIT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_COIN-1:0] coin_pulse,
  input  logic                buy_req,
  input  logic [CREDIT_W-1:0] price,
  input  logic                refund_req,
  output logic                buy_ack,
  output logic                buy_ok,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit
);

  localparam int SUM_W = CREDIT_W + 2;
  localparam logic [SUM_W-1:0] MAX_S = SUM_W'(MAX_CREDIT);

  logic [SUM_W-1:0] coin_in;

  coin_adder #(
    .NUM_COIN (NUM_COIN),
    .OUT_W    (SUM_W),
    .COIN_VAL (COIN_VAL)
  ) u_coin_adder (
    .coin_pulse (coin_pulse),
    .coin_in    (coin_in)
  );

  credit_state_t     state_q, state_d;
  logic [CREDIT_W-1:0] price_q, price_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
  logic              buy_ack_q, buy_ack_d;
  logic              buy_ok_q, buy_ok_d;
  logic              change_valid_q, change_valid_d;
  logic              coin_reject_q, coin_reject_d;
  logic [SUM_W-1:0]  base;
  logic [SUM_W-1:0]  total;

  always_comb begin
    state_d        = state_q;
    price_d        = price_q;
    credit_d       = credit_q;
    change_amt_d   = '0;
    buy_ack_d      = 1'b0;
    buy_ok_d       = 1'b0;
    change_valid_d = 1'b0;
    coin_reject_d  = 1'b0;
    base           = SUM_W'(credit_q);

    case (state_q)
      IDLE: begin
        if (buy_req) begin
          price_d = price;
          state_d = VEND;
        end else if (refund_req) begin
          state_d = REFUND;
        end
      end
      VEND: begin
        buy_ack_d = 1'b1;
        if (credit_q >= price_q) begin
          buy_ok_d = 1'b1;
          base     = SUM_W'(credit_q) - SUM_W'(price_q);
        end
        state_d = WAIT_REL;
      end
      REFUND: begin
        change_valid_d = 1'b1;
        state_d        = WAIT_REL;
      end
      WAIT_REL: begin
        if (!buy_req && !refund_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Coins are checked against the post-action base; a refund pays them out unsaturated.
    total = base + coin_in;
    if (state_q == REFUND) begin
      credit_d     = '0;
      change_amt_d = total[CREDIT_W-1:0];
    end else if (total <= MAX_S) begin
      credit_d = total[CREDIT_W-1:0];
    end else begin
      credit_d      = base[CREDIT_W-1:0];
      coin_reject_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      price_q        <= '0;
      credit_q       <= '0;
      change_amt_q   <= '0;
      buy_ack_q      <= 1'b0;
      buy_ok_q       <= 1'b0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      price_q        <= price_d;
      credit_q       <= credit_d;
      change_amt_q   <= change_amt_d;
      buy_ack_q      <= buy_ack_d;
      buy_ok_q       <= buy_ok_d;
      change_valid_q <= change_valid_d;
      coin_reject_q  <= coin_reject_d;
    end
  end

  assign buy_ack      = buy_ack_q;
  assign buy_ok       = buy_ok_q;
  assign change_valid = change_valid_q;
  assign change_amt   = change_amt_q;
  assign coin_reject  = coin_reject_q;
  assign credit       = credit_q;

endmodule
`default_nettype wire

// File: tb/tb_credit_accum.sv
`default_nettype none
// ============================================================================
// tb_credit_accum : directed scenarios plus random traffic against a cents model
// Rev 1.0
// ============================================================================
module tb_credit_accum;

  localparam int MAXC = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] coin_pulse;
  logic       buy_req;
  logic [6:0] price;
  logic       refund_req;
  logic       buy_ack;
  logic       buy_ok;
  logic       change_valid;
  logic [6:0] change_amt;
  logic       coin_reject;
  logic [6:0] credit;

  always #5 clk = ~clk;

  credit_accum dut (
    .clk          (clk),
    .reset        (reset),
    .coin_pulse   (coin_pulse),
    .buy_req      (buy_req),
    .price        (price),
    .refund_req   (refund_req),
    .buy_ack      (buy_ack),
    .buy_ok       (buy_ok),
    .change_valid (change_valid),
    .change_amt   (change_amt),
    .coin_reject  (coin_reject),
    .credit       (credit)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int coin_cents [3];

  // Reference: credit in cents plus pending-decision flags.
  int m_credit, m_price;
  bit m_vend_due, m_refund_due, m_locked;
  int e_ack, e_ok, e_cv, e_amt, e_rej;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credit = 0; m_price = 0;
    m_vend_due = 0; m_refund_due = 0; m_locked = 0;
    e_ack = 0; e_ok = 0; e_cv = 0; e_amt = 0; e_rej = 0;
  endtask

  task automatic model_step();
    int  coin = 0;
    int  base;
    bit  refunded = 0;
    for (int i = 0; i < 3; i++) if (coin_pulse[i]) coin += coin_cents[i];
    base = m_credit;
    e_ack = 0; e_ok = 0; e_cv = 0; e_amt = 0; e_rej = 0;
    if (m_vend_due) begin
      e_ack = 1;
      if (m_credit >= m_price) begin
        e_ok = 1;
        base = m_credit - m_price;
      end
      m_vend_due = 0;
      m_locked   = 1;
    end else if (m_refund_due) begin
      e_cv  = 1;
      e_amt = (m_credit + coin) % 128;
      refunded     = 1;
      m_refund_due = 0;
      m_locked     = 1;
    end else if (m_locked) begin
      if (!buy_req && !refund_req) m_locked = 0;
    end else if (buy_req) begin
      m_vend_due = 1;
      m_price    = int'(price);
    end else if (refund_req) begin
      m_refund_due = 1;
    end
    if (refunded) m_credit = 0;
    else if (base + coin <= MAXC) m_credit = base + coin;
    else begin
      m_credit = base;
      e_rej    = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else model_step();
    #1;
    check("credit", credit, m_credit);
    check("buy_ack", buy_ack, e_ack);
    check("buy_ok", buy_ok, e_ok);
    check("change_valid", change_valid, e_cv);
    check("change_amt", change_amt, e_amt);
    check("coin_reject", coin_reject, e_rej);
  endtask

  task automatic coin(input logic [2:0] p);
    coin_pulse = p;
    tick();
    coin_pulse = '0;
  endtask

  task automatic do_refund(output int amt);
    amt = -1;
    refund_req = 1'b1;
    for (int k = 0; k < 6 && amt < 0; k++) begin
      tick();
      if (change_valid) amt = int'(change_amt);
    end
    check("refund_seen", int'(amt >= 0), 1);
    refund_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic set_credit(input int target);
    int a;
    int r;
    do_refund(a);
    r = target;
    while (r >= 25) begin coin(3'b100); r -= 25; end
    while (r >= 10) begin coin(3'b010); r -= 10; end
    while (r >= 5)  begin coin(3'b001); r -= 5;  end
    check("set_credit", credit, target);
  endtask

  initial begin
    int amt;
    int acks, ack_at, ok_seen, cvs;

    coin_cents[0] = 5; coin_cents[1] = 10; coin_cents[2] = 25;
    reset = 1'b0; coin_pulse = '0; buy_req = 1'b0; price = '0; refund_req = 1'b0;
    model_reset();
    tick();
    tick();
    reset = 1'b1;

    // Single coins on consecutive cycles
    coin(3'b001); check("s1_credit5", credit, 5);
    coin(3'b010); check("s1_credit15", credit, 15);
    coin(3'b100); check("s1_credit40", credit, 40);
    check("s1_no_reject", coin_reject, 0);

    // Over-max coins refused as a whole
    set_credit(90);
    coin(3'b011);
    check("s2_reject", coin_reject, 1);
    check("s2_credit90", credit, 90);
    coin(3'b001);
    check("s2_reject_clear", coin_reject, 0);
    check("s2_credit95", credit, 95);

    // Held buy_req yields a single ack
    set_credit(40);
    buy_req = 1'b1; price = 7'd35;
    acks = 0; ack_at = 0; ok_seen = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (buy_ack) begin acks++; ack_at = k; ok_seen = buy_ok; end
    end
    check("s3_ack_count", acks, 1);
    check("s3_ack_latency", ack_at, 2);
    check("s3_buy_ok", ok_seen, 1);
    check("s3_credit5", credit, 5);
    buy_req = 1'b0; tick(); tick();

    // Insufficient credit, then refund
    set_credit(30);
    buy_req = 1'b1; price = 7'd35;
    acks = 0; ok_seen = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (buy_ack) begin acks++; ok_seen = buy_ok; end
    end
    check("s4_ack_count", acks, 1);
    check("s4_buy_ok0", ok_seen, 0);
    check("s4_credit30", credit, 30);
    buy_req = 1'b0; tick(); tick();
    do_refund(amt);
    check("s4_change30", amt, 30);
    check("s4_credit0", credit, 0);

    // Simultaneous buy and refund: buy wins
    set_credit(50);
    buy_req = 1'b1; refund_req = 1'b1; price = 7'd20;
    acks = 0; cvs = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (buy_ack) acks++;
      if (change_valid) cvs++;
    end
    check("s5_ack_count", acks, 1);
    check("s5_no_change", cvs, 0);
    check("s5_credit30", credit, 30);
    buy_req = 1'b0; refund_req = 1'b0; tick(); tick();
    do_refund(amt);
    check("s5_change30", amt, 30);

    // Coin during the VEND cycle, then reset mid-refund
    set_credit(60);
    buy_req = 1'b1; price = 7'd60;
    tick();
    coin_pulse = 3'b010;
    tick();
    coin_pulse = '0;
    check("s6_ack", buy_ack, 1);
    check("s6_ok", buy_ok, 1);
    check("s6_credit10", credit, 10);
    buy_req = 1'b0; tick(); tick();
    refund_req = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("s6_rst_credit", credit, 0);
    check("s6_rst_cv", change_valid, 0);
    model_reset();
    tick(); tick();
    refund_req = 1'b0; reset = 1'b1;
    tick(); tick();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if (!reset) reset = 1'b1;
      coin_pulse = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      if (buy_req) begin
        if ($urandom_range(0, 3) == 0) buy_req = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        buy_req = 1'b1;
        price = ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom_range(0, 110));
      end
      if (refund_req) begin
        if ($urandom_range(0, 2) == 0) refund_req = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        refund_req = 1'b1;
      end
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
        #1;
        check("rnd_rst_credit", credit, 0);
        check("rnd_rst_ack", buy_ack, 0);
        model_reset();
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
